// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI execute-in-place reader.
//   qspi_state_e   : controller FSM states
//   QSPI_OPCODE    : Fast Read Quad I/O opcode sent at the start of every burst
//   QSPI_MODE_BITS : nibble driven during the mode-bit part of the dummy phase
//   max3()         : elaboration-time helper for sizing the phase counter
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_CSH   = 3'd5
    } qspi_state_e;

    localparam logic [7:0] QSPI_OPCODE    = 8'hEB;
    localparam logic [3:0] QSPI_MODE_BITS = 4'h0;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/qspi_nibble_asm.sv
// Collects 8 sampled nibbles into one 32-bit word, byte little-endian:
// nibble 2j lands in bits [8j+7:8j+4], nibble 2j+1 in bits [8j+3:8j].
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : restart assembly at nibble 0
//   sample_en   : capture nib_i this cycle
//   nib_i       : sampled IO nibble
//   word_o      : assembled word (valid when word_done_o is high)
//   word_done_o : one-cycle strobe, high the cycle after the 8th nibble
module qspi_nibble_asm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        sample_en,
    input  logic [3:0]  nib_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [2:0] idx_q, idx_d;
    logic       done_q, done_d;

    always_comb begin
        idx_d  = idx_q;
        done_d = 1'b0;
        if (clr) begin
            idx_d = 3'd0;
        end else if (sample_en) begin
            idx_d  = idx_q + 3'd1;
            done_d = (idx_q == 3'd7);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 3'd0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
        logic [3:0] slot_q, slot_d;

        assign slot_d = (sample_en && !clr && idx_q == 3'(gi)) ? nib_i : slot_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_q <= 4'h0;
            end else begin
                slot_q <= slot_d;
            end
        end

        // Even nibbles are the high half of their byte.
        assign word_o[8*(gi/2) + ((gi % 2 == 0) ? 4 : 0) +: 4] = slot_q;
    end

    assign word_done_o = done_q;

endmodule

// File: rtl/qspi_xip_reader.sv
// QSPI flash XIP burst reader (opcode EB, quad address/data, SPI mode 0, SCK = clk/2).
//   clk, reset       : clock, asynchronous active-low reset (release synchronised)
//   start/addr/len   : burst request; len is words minus one; captured on accept
//   abort            : end the active burst, go straight to CS-high hold
//   busy             : high from accept until the CS-high hold completes
//   rd_data/rd_valid : assembled 32-bit word and its one-cycle qualifier
//   done             : one-cycle pulse with the final word of a complete burst
//   spi_*            : flash pins; spi_io_i is sampled as SCK falls
module qspi_xip_reader
    import qspi_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int DUMMY_CYCLES = 6,
    parameter int CMD_QUAD     = 0,
    parameter int LEN_W        = 4,
    parameter int CS_HIGH_CLKS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic [3:0]        spi_io_o,
    output logic [3:0]        spi_io_oe,
    input  logic [3:0]        spi_io_i
);

    localparam int unsigned CMD_SCK  = (CMD_QUAD != 0) ? 2 : 8;
    localparam int unsigned ADDR_NIB = ADDR_W / 4;
    localparam int unsigned CNT_MAX  = max3(ADDR_NIB, 15, 8 * (1 << LEN_W));
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(CMD_SCK - 1);
    localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(ADDR_NIB - 1);
    localparam logic [CNT_W-1:0] CNT_DUMMY = CNT_W'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_CSH   = CNT_W'(CS_HIGH_CLKS - 1);

    // Reset: asserts immediately, releases two clk edges later.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end
    assign rst_n = rst_sync_q[1];

    qspi_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sck_q, sck_d, cs_n_q, cs_n_d, tail_q, tail_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_shift;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [3:0]        io_o_q, io_o_d, io_oe_q, io_oe_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d, done_q, done_d;
    logic              active, kill, fall, sample_en, asm_clr;
    logic [31:0]       asm_word;
    logic              asm_done;

    assign active = (state_q inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA});
    assign kill   = active && abort;
    assign fall   = sck_q;      // this edge drives SCK low

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tail_d    = tail_q;
        addr_d    = addr_q;
        len_d     = len_q;
        sample_en = 1'b0;
        asm_clr   = 1'b0;
        // SCK toggles through every transfer phase; tail_q marks the wait
        // after the last data nibble where the bus stays idle.
        sck_d     = (active && !tail_q) ? ~sck_q : 1'b0;

        case (state_q)
            ST_IDLE: begin
                tail_d = 1'b0;
                if (start && !abort) begin
                    state_d = ST_CMD;
                    cnt_d   = CNT_CMD;
                    addr_d  = addr;
                    len_d   = len;
                    asm_clr = 1'b1;
                end
            end
            ST_CMD: if (fall) begin
                if (cnt_q == '0) begin
                    state_d = ST_ADDR;
                    cnt_d   = CNT_ADDR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ADDR: if (fall) begin
                if (cnt_q == '0) begin
                    if (DUMMY_CYCLES > 0) begin
                        state_d = ST_DUMMY;
                        cnt_d   = CNT_DUMMY;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_W'({len_q, 3'b111});
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DUMMY: if (fall) begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_W'({len_q, 3'b111});
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (tail_q) begin
                    // Leave once the final word has been presented with done.
                    if (done_q) begin
                        state_d = ST_CSH;
                        cnt_d   = CNT_CSH;
                        tail_d  = 1'b0;
                    end
                end else if (fall) begin
                    sample_en = 1'b1;
                    if (cnt_q == '0) begin
                        tail_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_CSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (kill) begin
            state_d   = ST_CSH;
            cnt_d     = CNT_CSH;
            sck_d     = 1'b0;
            tail_d    = 1'b0;
            sample_en = 1'b0;
        end

        cs_n_d = !(state_d inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA});

        // IO drive follows the phase/count being entered, so it changes only
        // on the edges that lower SCK (and on the accept edge).
        addr_shift = addr_d >> {cnt_d, 2'b00};
        io_o_d     = 4'h0;
        io_oe_d    = 4'h0;
        case (state_d)
            ST_CMD: begin
                io_oe_d = 4'hF;
                if (CMD_QUAD != 0) begin
                    io_o_d = cnt_d[0] ? QSPI_OPCODE[7:4] : QSPI_OPCODE[3:0];
                end else begin
                    io_o_d = {3'b111, QSPI_OPCODE[cnt_d[2:0]]};
                end
            end
            ST_ADDR: begin
                io_oe_d = 4'hF;
                io_o_d  = addr_shift[3:0];
            end
            ST_DUMMY: begin
                io_o_d  = QSPI_MODE_BITS;
                // Mode bits occupy the first two dummy SCK, then turnaround.
                io_oe_d = (int'(cnt_d) + 2 >= DUMMY_CYCLES) ? 4'hF : 4'h0;
            end
            default: ;
        endcase

        rd_valid_d = asm_done && (state_q == ST_DATA) && !kill;
        done_d     = rd_valid_d && tail_q;
        rd_data_d  = rd_valid_d ? asm_word : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            tail_q     <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            io_o_q     <= 4'h0;
            io_oe_q    <= 4'h0;
            rd_data_q  <= 32'h0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            tail_q     <= tail_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            io_o_q     <= io_o_d;
            io_oe_q    <= io_oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    qspi_nibble_asm u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (asm_clr),
        .sample_en   (sample_en),
        .nib_i       (spi_io_i),
        .word_o      (asm_word),
        .word_done_o (asm_done)
    );

    assign busy      = (state_q != ST_IDLE);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_sck   = sck_q;
    assign spi_io_o  = io_o_q;
    assign spi_io_oe = io_oe_q;

endmodule

// File: tb/tb_qspi_xip_reader.sv
module tb_qspi_xip_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, sel;
    logic [31:0] addr;
    logic [3:0]  len;
    logic        start_d, start_q, abort_d, abort_q;

    always #5 clk = ~clk;

    assign start_d = start & ~sel;
    assign start_q = start & sel;
    assign abort_d = abort & ~sel;
    assign abort_q = abort & sel;

    // Instance d: all defaults. Instance q: QPI opcode, 32-bit address, no dummy.
    logic        d_busy, d_valid, d_done, d_cs_n, d_sck;
    logic [31:0] d_data;
    logic [3:0]  d_io_o, d_io_oe;
    logic [3:0]  d_io_i = 4'h0;
    logic        q_busy, q_valid, q_done, q_cs_n, q_sck;
    logic [31:0] q_data;
    logic [3:0]  q_io_o, q_io_oe;
    logic [3:0]  q_io_i = 4'h0;

    qspi_xip_reader dut_d (
        .clk(clk), .reset(reset), .start(start_d), .addr(addr[23:0]), .len(len),
        .abort(abort_d), .busy(d_busy), .rd_data(d_data), .rd_valid(d_valid),
        .done(d_done), .spi_cs_n(d_cs_n), .spi_sck(d_sck), .spi_io_o(d_io_o),
        .spi_io_oe(d_io_oe), .spi_io_i(d_io_i)
    );

    qspi_xip_reader #(.ADDR_W(32), .DUMMY_CYCLES(0), .CMD_QUAD(1)) dut_q (
        .clk(clk), .reset(reset), .start(start_q), .addr(addr), .len(len),
        .abort(abort_q), .busy(q_busy), .rd_data(q_data), .rd_valid(q_valid),
        .done(q_done), .spi_cs_n(q_cs_n), .spi_sck(q_sck), .spi_io_o(q_io_o),
        .spi_io_oe(q_io_oe), .spi_io_i(q_io_i)
    );

    // Flash models: log opcode/address/oe on SCK rise, return data nibble k as k+1.
    int          d_r, d_oe_err, d_hi_err, q_r, q_oe_err;
    logic [7:0]  d_op, q_op;
    logic [31:0] d_adr, q_adr;

    always @(posedge d_sck or negedge d_cs_n) begin
        if (d_sck && !d_cs_n) begin
            d_r++;
            if (d_r <= 8) begin
                d_op = {d_op[6:0], d_io_o[0]};
                if (d_io_o[3:1] != 3'b111) d_hi_err++;
            end else if (d_r <= 14) begin
                d_adr = {d_adr[27:0], d_io_o};
            end
            if (d_io_oe != ((d_r <= 16) ? 4'hF : 4'h0)) d_oe_err++;
            if (d_r > 20) d_io_i = 4'(d_r - 20);
        end else begin
            d_r = 0; d_op = 8'h0; d_adr = 32'h0; d_oe_err = 0; d_hi_err = 0;
        end
    end

    always @(posedge q_sck or negedge q_cs_n) begin
        if (q_sck && !q_cs_n) begin
            q_r++;
            if (q_r <= 2) q_op = {q_op[3:0], q_io_o};
            else if (q_r <= 10) q_adr = {q_adr[27:0], q_io_o};
            if (q_io_oe != ((q_r <= 10) ? 4'hF : 4'h0)) q_oe_err++;
            if (q_r > 10) q_io_i = 4'(q_r - 10);
        end else begin
            q_r = 0; q_op = 8'h0; q_adr = 32'h0; q_oe_err = 0;
        end
    end

    logic        o_busy, o_valid, o_done, o_cs_n, o_sck;
    logic [31:0] o_data;
    assign o_busy  = sel ? q_busy  : d_busy;
    assign o_valid = sel ? q_valid : d_valid;
    assign o_done  = sel ? q_done  : d_done;
    assign o_cs_n  = sel ? q_cs_n  : d_cs_n;
    assign o_sck   = sel ? q_sck   : d_sck;
    assign o_data  = sel ? q_data  : d_data;

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [3:0]  l;
        int          abort_t;
        logic        hold;
        int          words;
        int          first;
        int          dn;
    } vec_t;

    vec_t        vecs[7];
    int          v_t[$];
    logic [31:0] v_data[$];
    int          done_n, done_t, csh_t, idle_t, cs_err, sck_err;

    // t counts negedges after the accept edge: t=0 shows state just after it.
    task automatic run_burst(input vec_t v);
        v_t.delete(); v_data.delete();
        done_n = 0; done_t = -1; csh_t = -1; idle_t = -1; cs_err = 0; sck_err = 0;
        @(negedge clk);
        sel = v.s; addr = v.a; len = v.l; start = 1'b1; abort = 1'b0;
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            if (o_valid) begin v_t.push_back(t); v_data.push_back(o_data); end
            if (o_done) begin done_n++; done_t = t; end
            if (o_cs_n && o_sck) sck_err++;
            if (csh_t < 0) begin
                if (o_cs_n) csh_t = t;
            end else if (!o_cs_n) begin
                cs_err++;
            end
            if (!v.hold) start = 1'b0;
            addr  = ~v.a;
            len   = ~v.l;
            abort = (t == v.abort_t);
            if (!o_busy) begin
                idle_t = t; start = 1'b0; abort = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_vec(input int id, input vec_t v);
        int last, exp_csh;
        run_burst(v);
        last    = v.first + 16 * (v.words - 1);
        exp_csh = (v.abort_t >= 0) ? v.abort_t + 1 : last + 1;
        chk("timeout", (idle_t >= 0), 1'b1);
        chk("word_count", v_t.size(), v.words);
        for (int i = 0; i < v_t.size() && i < v.words; i++) begin
            chk("valid_time", v_t[i], v.first + 16 * i);
            chk("rd_data", v_data[i], (i % 2 == 0) ? 32'h78563412 : 32'hF0DEBC9A);
        end
        chk("done_count", done_n, v.dn);
        if (v.dn > 0) chk("done_time", done_t, last);
        chk("cs_rise", csh_t, exp_csh);
        chk("busy_end", idle_t, exp_csh + 4);
        chk("cs_stays_high", cs_err, 0);
        chk("sck_low_cs_high", sck_err, 0);
        if (v.abort_t < 0) begin
            chk("opcode", v.s ? q_op : d_op, 8'hEB);
            chk("address", v.s ? q_adr : d_adr, v.s ? v.a : {8'h0, v.a[23:0]});
            chk("oe_pattern", v.s ? q_oe_err : d_oe_err, 0);
            chk("io_hi_ones", d_hi_err, 0);
        end
        $display("vec %0d: sel=%0d addr=%h len=%0d words=%0d done=%0d cs_rise=%0d idle=%0d",
                 id, v.s, v.a, v.l, v_t.size(), done_n, csh_t, idle_t);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h00012345, 4'd0,  -1, 1'b0, 1,  57, 1};
        vecs[1] = '{1'b0, 32'h00ABCDEF, 4'd3,  -1, 1'b0, 4,  57, 1};
        vecs[2] = '{1'b0, 32'h00000000, 4'd15, -1, 1'b0, 16, 57, 1};
        vecs[3] = '{1'b1, 32'h89ABCDEF, 4'd1,  -1, 1'b0, 2,  37, 1};
        vecs[4] = '{1'b0, 32'h00102030, 4'd2,  65, 1'b0, 1,  57, 0};
        vecs[5] = '{1'b0, 32'h00FFFFFE, 4'd1,  -1, 1'b1, 2,  57, 1};
        vecs[6] = '{1'b1, 32'h00000001, 4'd0,  10, 1'b0, 0,  37, 0};

        reset = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0; addr = 32'h0; len = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_ctl_d", {d_cs_n, d_sck, d_io_o, d_io_oe, d_busy, d_valid, d_done}, 13'h1000);
        chk("rst_ctl_q", {q_cs_n, q_sck, q_io_o, q_io_oe, q_busy, q_valid, q_done}, 13'h1000);
        chk("rst_data", d_data | q_data, 32'h0);

        // Start presented together with reset release must not be taken at once.
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("rst_release_start", d_busy, 1'b0);
        start = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            check_vec(i, vecs[i]);
            if (i == 0) begin
                repeat (5) @(negedge clk);
                chk("rd_data_hold", d_data, 32'h78563412);
            end
        end

        // Coincident start and abort in IDLE: the start is dropped.
        @(negedge clk);
        sel = 1'b0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", d_busy, 1'b0);
        chk("start_abort_cs", d_cs_n, 1'b1);
        repeat (3) @(negedge clk);
        chk("start_abort_noqueue", d_busy, 1'b0);
        $display("seq start+abort in idle: busy=%0d cs_n=%0d", d_busy, d_cs_n);

        // Reset pulsed in the middle of the address phase.
        @(negedge clk);
        sel = 1'b0; addr = 32'h00C0FFEE; len = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_reset_cs_low", d_cs_n, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midreset_ctl", {d_cs_n, d_sck, d_io_oe, d_busy}, 7'b1000000);
        $display("seq reset mid-addr: cs_n=%0d sck=%0d oe=%h busy=%0d", d_cs_n, d_sck, d_io_oe, d_busy);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_vec(7, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
